// File: rtl/iot_event_reporter_if.sv
// -----------------------------------------------------------------------------
// iot_event_reporter_if
// Bundles the device level inputs and the event strobe outputs of
// iot_event_reporter.
//   dev_active   [N_DEV] per-device on/off level (driven by the slave side)
//   change              one-cycle strobe: an event is reported this cycle
//   on_off              direction of the reported event (1 = on)
//   dev_id       [ID_W] index of the reported device
//   busy                any event still pending
//   shadow_count [8]    running on-minus-off total
//                       (present only with IOT_REPORTER_SHADOW_EN)
// Modports: master = reporter, slave = environment / downstream counter.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface iot_event_reporter_if #(
    parameter int unsigned N_DEV = 8,
    parameter int unsigned ID_W  = 3
);
    logic [N_DEV-1:0] dev_active;
    logic             change;
    logic             on_off;
    logic [ID_W-1:0]  dev_id;
    logic             busy;
`ifdef IOT_REPORTER_SHADOW_EN
    logic [7:0]       shadow_count;

    modport master (
        input  dev_active,
        output change, on_off, dev_id, busy, shadow_count
    );
    modport slave (
        output dev_active,
        input  change, on_off, dev_id, busy, shadow_count
    );
`else
    modport master (
        input  dev_active,
        output change, on_off, dev_id, busy
    );
    modport slave (
        output dev_active,
        input  change, on_off, dev_id, busy
    );
`endif
endinterface

// File: rtl/iot_event_reporter.sv
// -----------------------------------------------------------------------------
// iot_event_reporter
// Detects on/off transitions on up to N_DEV device levels, holds each as a
// pending event and reports them one per cycle as registered change/on_off/
// dev_id strobes, arbitrated round-robin. An edge opposite to a still-pending
// event cancels it, so the downstream counter never sees the glitch.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - iot_event_reporter_if.master (dev_active in; change, on_off,
//          dev_id, busy and optional shadow_count out)
// Optional feature: define IOT_REPORTER_SHADOW_EN to add bus.shadow_count, an
// 8-bit wrapping count of reported ons minus reported offs.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module iot_event_reporter #(
    parameter int unsigned N_DEV = 8,
    parameter int unsigned ID_W  = 3
) (
    input logic                  clk,
    input logic                  rst,
    iot_event_reporter_if.master bus
);

    logic [N_DEV-1:0] r_dev_q;
    logic [N_DEV-1:0] r_pend;
    logic [N_DEV-1:0] r_pdir;
    logic [ID_W-1:0]  r_ptr;
    logic             r_change;
    logic             r_on_off;
    logic [ID_W-1:0]  r_dev_id;

    logic [N_DEV-1:0] w_rise;
    logic [N_DEV-1:0] w_fall;
    logic [N_DEV-1:0] w_edge;
    logic [N_DEV-1:0] w_gnt_mask;
    logic [N_DEV-1:0] w_pend_left;
    logic [N_DEV-1:0] w_new;
    logic [N_DEV-1:0] w_pend_nxt;
    logic [N_DEV-1:0] w_pdir_nxt;
    logic             w_gnt_vld;
    logic [ID_W-1:0]  w_gnt_idx;
    logic [ID_W-1:0]  w_ptr_nxt;

    // (base + off) mod N_DEV; base < N_DEV and off <= N_DEV so one subtract suffices
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                                 input int unsigned     off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= N_DEV) begin
            s = s - N_DEV;
        end
        return ID_W'(s);
    endfunction

    assign w_rise = bus.dev_active & ~r_dev_q;
    assign w_fall = ~bus.dev_active & r_dev_q;
    assign w_edge = w_rise | w_fall;

    // Round-robin grant: first pending index starting at r_ptr
    always_comb begin
        w_gnt_vld  = 1'b0;
        w_gnt_idx  = '0;
        w_gnt_mask = '0;
        for (int unsigned k = 0; k < N_DEV; k++) begin
            if (!w_gnt_vld && r_pend[wrap_add(r_ptr, k)]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = wrap_add(r_ptr, k);
            end
        end
        if (w_gnt_vld) begin
            w_gnt_mask[w_gnt_idx] = 1'b1;
        end
        w_ptr_nxt = wrap_add(w_gnt_idx, 1);
    end

    // After the grant clear, an edge on an idle device opens a new event and an
    // edge on a still-pending device can only be the opposite direction, which
    // cancels it. Both cases reduce to toggling the pending bit.
    assign w_pend_left = r_pend & ~w_gnt_mask;
    assign w_new       = w_edge & ~w_pend_left;
    assign w_pend_nxt  = w_pend_left ^ w_edge;
    assign w_pdir_nxt  = (w_new & w_rise) | (~w_new & r_pdir);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dev_q  <= '0;
            r_pend   <= '0;
            r_pdir   <= '0;
            r_ptr    <= '0;
            r_change <= 1'b0;
            r_on_off <= 1'b0;
            r_dev_id <= '0;
        end else begin
            r_dev_q  <= bus.dev_active;
            r_pend   <= w_pend_nxt;
            r_pdir   <= w_pdir_nxt;
            r_change <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_on_off <= r_pdir[w_gnt_idx];
                r_dev_id <= w_gnt_idx;
                r_ptr    <= w_ptr_nxt;
            end
        end
    end

`ifdef IOT_REPORTER_SHADOW_EN
    logic [7:0] r_shadow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow <= 8'd0;
        end else if (w_gnt_vld) begin
            r_shadow <= r_pdir[w_gnt_idx] ? r_shadow + 8'd1 : r_shadow - 8'd1;
        end
    end

    assign bus.shadow_count = r_shadow;
`endif

    assign bus.change = r_change;
    assign bus.on_off = r_on_off;
    assign bus.dev_id = r_dev_id;
    assign bus.busy   = |r_pend;

endmodule
